mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mmix_defs.sv | 16 +
 rtl/mem_rr_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mmix_defs.sv
// Shared MMIX memory-subsystem definitions.
// Arbiter FSM states and the fetch/data port-select encoding.
package mmix_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_F = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SEL_F = 1'b0,
        SEL_D = 1'b1
    } port_sel_t;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-port winner selection: round-robin or data-first.
// Ports: i_req_f/i_req_d requests, i_last last grant, o_win winner.
module mem_rr_pick
    import mmix_defs::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic      i_req_f,
    input  logic      i_req_d,
    input  port_sel_t i_last,
    output port_sel_t o_win
);

    always_comb begin
        o_win = SEL_D;
        unique case (1'b1)
            (i_req_f && !i_req_d): o_win = SEL_F;
            (i_req_d && !i_req_f): o_win = SEL_D;
            (i_req_f && i_req_d):
                o_win = (FAIR && i_last == SEL_D) ? SEL_F : SEL_D;
            default: o_win = SEL_D;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one registered memory port.
// Ports: f_* fetch, d_* data, m_* memory, rdata/bus_err/proto_err status.
module mem_arbiter
    import mmix_defs::*;
#(
    parameter bit          FAIR    = 1'b1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] f_address,
    input  logic [1:0]  f_datasize,
    input  logic        f_read,
    output logic        f_done,
    input  logic [63:0] d_address,
    input  logic [1:0]  d_datasize,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [63:0] d_writedata,
    output logic        d_done,
    output logic [63:0] rdata,
    output logic        bus_err,
    output logic        proto_err,
    output logic [63:0] m_address,
    output logic [1:0]  m_datasize,
    output logic        m_read,
    output logic        m_write,
    output logic [63:0] m_writedata,
    input  logic [63:0] m_readdata,
    input  logic        m_done
);

    // Timeout fires in the cycle whose increment would reach TIMEOUT.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    arb_state_t  r_state;
    arb_state_t  w_next;
    port_sel_t   r_last;
    port_sel_t   w_win;
    logic [15:0] r_cnt;
    logic [63:0] r_m_address;
    logic [1:0]  r_m_datasize;
    logic        r_m_read;
    logic        r_m_write;
    logic [63:0] r_m_writedata;
    logic        r_proto;
    logic        w_any;
    logic        w_timeout;
    logic        w_finish;

    assign w_any = f_read || d_read || d_write;

    mem_rr_pick #(
        .FAIR (FAIR)
    ) u_pick (
        .i_req_f (f_read),
        .i_req_d (d_read || d_write),
        .i_last  (r_last),
        .o_win   (w_win)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_finish  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = (w_win == SEL_F) ? GRANT_F : GRANT_D;
                end
            end
            GRANT_F, GRANT_D: begin
                // m_done beats a coincident timeout.
                w_timeout = !m_done && (r_cnt == TO_LAST);
                w_finish  = m_done || w_timeout;
                if (w_finish) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last        <= SEL_D;
            r_cnt         <= '0;
            r_m_address   <= '0;
            r_m_datasize  <= '0;
            r_m_read      <= 1'b0;
            r_m_write     <= 1'b0;
            r_m_writedata <= '0;
            r_proto       <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (d_read && d_write) begin
                    r_proto <= 1'b1;
                end
                if (w_any) begin
                    r_cnt  <= '0;
                    r_last <= w_win;
                    if (w_win == SEL_F) begin
                        r_m_address  <= f_address;
                        r_m_datasize <= f_datasize;
                        r_m_read     <= 1'b1;
                        r_m_write    <= 1'b0;
                    end else begin
                        r_m_address   <= d_address;
                        r_m_datasize  <= d_datasize;
                        r_m_writedata <= d_writedata;
                        r_m_read      <= !d_write;
                        r_m_write     <= d_write;
                    end
                end
            end else if (w_finish) begin
                r_m_read  <= 1'b0;
                r_m_write <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign f_done      = (r_state == GRANT_F) && w_finish;
    assign d_done      = (r_state == GRANT_D) && w_finish;
    assign bus_err     = w_timeout;
    assign rdata       = m_readdata;
    assign proto_err   = r_proto;
    assign m_address   = r_m_address;
    assign m_datasize  = r_m_datasize;
    assign m_read      = r_m_read;
    assign m_write     = r_m_write;
    assign m_writedata = r_m_writedata;

endmodule
